// File: rtl/linear_layer_srl_fifo_mc.sv
// Multi-channel SRL stream FIFO: per-channel shift-register storage addressed by
// its occupancy counter, HLS full_n/empty_n handshake, almost-full and global flush.

module linear_layer_srl_fifo_mc_ch #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int CW         = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  flush,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_read,
    output logic                  o_full_n,
    output logic                  o_empty_n,
    output logic                  o_almost_full,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [CW-1:0]         o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_srl [DEPTH];
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;
    logic [AW-1:0]         w_head;

    assign o_full_n      = (r_count != CW'(DEPTH));
    assign o_empty_n     = (r_count != '0);
    assign o_almost_full = (r_count >= CW'(AF_LEVEL));
    assign o_count       = r_count;

    // A full channel refuses writes even when a pop lands in the same cycle.
    assign w_push = i_write & o_full_n & ~flush;
    assign w_pop  = i_read  & o_empty_n & ~flush;

    // Oldest entry sits at count-1; pin the index to 0 when empty so it stays in range.
    assign w_head = (r_count == '0) ? '0 : AW'(r_count - CW'(1));
    assign o_dout = r_srl[w_head];

    // Data path carries no reset so it maps onto shift-register primitives.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_srl[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_srl[i] <= r_srl[i-1];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)             r_count <= '0;
        else if (flush)            r_count <= '0;
        else if (w_push && !w_pop) r_count <= r_count + CW'(1);
        else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
endmodule

module linear_layer_srl_fifo_mc #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int CHANNELS   = 4,
    parameter  int AF_LEVEL   = DEPTH - 2,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           flush,
    input  logic [CHANNELS-1:0]            if_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0] if_din,
    output logic [CHANNELS-1:0]            if_full_n,
    output logic [CHANNELS-1:0]            if_almost_full,
    input  logic [CHANNELS-1:0]            if_read,
    output logic [CHANNELS*DATA_WIDTH-1:0] if_dout,
    output logic [CHANNELS-1:0]            if_empty_n,
    output logic [CHANNELS*CW-1:0]         count
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        linear_layer_srl_fifo_mc_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (AF_LEVEL),
            .CW         (CW)
        ) u_ch (
            .ap_clk        (ap_clk),
            .ap_rst_n      (ap_rst_n),
            .flush         (flush),
            .i_write       (if_write[c]),
            .i_din         (if_din[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_read        (if_read[c]),
            .o_full_n      (if_full_n[c]),
            .o_empty_n     (if_empty_n[c]),
            .o_almost_full (if_almost_full[c]),
            .o_dout        (if_dout[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_count       (count[c*CW +: CW])
        );
    end
endmodule
